// File: rtl/sequential_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider
//
// Iterative restoring divider. Divides an unsigned N-bit dividend by an
// unsigned N-bit divisor, producing one quotient bit per clock, so a division
// takes N cycles. A zero divisor is flagged on div_by_zero rather than
// trapped. The datapath still produces quotient = all ones and
// remainder = dividend in that case.
//
// Handshake: a request is start=1 sampled on a rising edge while busy=0.
// That edge captures dividend/divisor and drops ready. The result registers
// (quotient, remainder, div_by_zero) change only on the completion edge, which
// also raises ready. ready then holds until the next accepted start or reset.
// start is ignored while busy=1. busy and ready are never high together.
//
// Parameters:
//   N            operand width in bits (N >= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, priority over start
//   start        division request, sampled only while busy=0
//   busy         division in progress
//   ready        result valid
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   quotient     unsigned quotient of the last completed division
//   remainder    unsigned remainder of the last completed division
//   div_by_zero  last completed division had divisor = 0
//
// Build option:
//   DIVIDER_DBZ_SHORTCUT_EN  when defined, a start with divisor = 0 completes
//                            on the accepting edge. It never enters RUN.
// ---------------------------------------------------------------------------
module sequential_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           finish;
    logic           divisor_zero;

    logic [N-1:0]   sreg;        // dividend shifts out the top, quotient bits enter the bottom
    logic [N-1:0]   dsr;         // divisor holding register
    logic [N-1:0]   r;           // partial remainder; always < divisor, so N bits hold it
    logic [N:0]     r_shift;
    logic [N-1:0]   r_next;
    logic           q_bit;
    logic [N-1:0]   sreg_next;
    logic [CW-1:0]  cnt;
    logic           dbz_pend;
    logic           last_iter;

    assign divisor_zero = (divisor == '0);
    assign last_iter    = (cnt == CW'(N - 1));
    assign busy         = (state == RUN);

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
`ifdef DIVIDER_DBZ_SHORTCUT_EN
                    // A zero divisor is resolved on the accepting edge.
                    if (!divisor_zero) begin
                        state_next = RUN;
                    end
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                if (last_iter) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // One restoring step. The shifted value needs N+1 bits for the compare.
    // When it is >= divisor, the difference is < divisor and fits in N bits.
    // The low-N-bit subtract is therefore exact.
    // -----------------------------------------------------------------------
    always_comb begin
        r_shift = {r, sreg[N-1]};
        if (r_shift >= {1'b0, dsr}) begin
            q_bit  = 1'b1;
            r_next = r_shift[N-1:0] - dsr;
        end else begin
            q_bit  = 1'b0;
            r_next = r_shift[N-1:0];
        end
        sreg_next = {sreg[N-2:0], q_bit};
    end

    // -----------------------------------------------------------------------
    // Datapath and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ready       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            sreg        <= '0;
            dsr         <= '0;
            r           <= '0;
            cnt         <= '0;
            dbz_pend    <= 1'b0;
        end else if (accept) begin
            sreg     <= dividend;
            dsr      <= divisor;
            r        <= '0;
            cnt      <= '0;
            dbz_pend <= divisor_zero;
            ready    <= 1'b0;
`ifdef DIVIDER_DBZ_SHORTCUT_EN
            if (divisor_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
                ready       <= 1'b1;
            end
`endif
        end else if (state == RUN) begin
            sreg <= sreg_next;
            r    <= r_next;
            cnt  <= cnt + 1'b1;
            if (finish) begin
                quotient    <= sreg_next;
                remainder   <= r_next;
                div_by_zero <= dbz_pend;
                ready       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst;

  logic       start4;
  logic [3:0] dvd4, dvs4;
  logic       busy4, ready4, dbz4;
  logic [3:0] q4, r4;

  logic       start8;
  logic [7:0] dvd8, dvs8;
  logic       busy8, ready8, dbz8;
  logic [7:0] q8, r8;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];

`ifdef DIVIDER_DBZ_SHORTCUT_EN
  localparam int DBZ_LAT  = 0;
  localparam int DBZ_BUSY = 0;
`else
  localparam int DBZ_LAT  = 4;
  localparam int DBZ_BUSY = 4;
`endif

  sequential_divider #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .ready(ready4),
    .dividend(dvd4), .divisor(dvs4), .quotient(q4), .remainder(r4),
    .div_by_zero(dbz4)
  );

  sequential_divider #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .ready(ready8),
    .dividend(dvd8), .divisor(dvs8), .quotient(q8), .remainder(r8),
    .div_by_zero(dbz8)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ready and busy must never be high together
  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_busy_excl4", {31'b0, ready4 & busy4}, 32'd0);
      check("rdy_busy_excl8", {31'b0, ready8 & busy8}, 32'd0);
    end
  end

  // driver: one N=4 request. lat = edges after the accepting edge until ready.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat, output int busy_cnt);
    @(negedge clk);
    start4 = 1'b1; dvd4 = a; dvs4 = b;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!ready4 && lat < 40) begin
      if (busy4) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!ready4) check("timeout4", {31'b0, ready4}, 32'd1);
  endtask

  task automatic div4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input int eq, input int er, input int edbz, input int elat, input int ebusy);
    int lat, bc;
    run4(a, b, lat, bc);
    check({tag, "_q"},    {28'b0, q4}, eq);
    check({tag, "_r"},    {28'b0, r4}, er);
    check({tag, "_dbz"},  {31'b0, dbz4}, edbz);
    check({tag, "_lat"},  lat, elat);
    check({tag, "_busy"}, bc, ebusy);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1; dvd8 = a; dvs8 = b;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!ready8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ready8) check("timeout8", {31'b0, ready8}, 32'd1);
  endtask

  initial begin
    int lat;
    int a, b;
    logic [15:0] e;

    rst = 1'b1;
    start4 = 1'b0; dvd4 = '0; dvs4 = '0;
    start8 = 1'b0; dvd8 = '0; dvs8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'b0, busy4}, 0);
    check("rst_ready", {31'b0, ready4}, 0);
    check("rst_q",     {28'b0, q4}, 0);
    check("rst_r",     {28'b0, r4}, 0);
    check("rst_dbz",   {31'b0, dbz4}, 0);
    rst = 1'b0;

    // directed N=4 vectors
    div4("d13_4",  4'd13, 4'd4,  3,  1, 0, 4, 4);
    div4("d15_1",  4'd15, 4'd1,  15, 0, 0, 4, 4);
    div4("d7_9",   4'd7,  4'd9,  0,  7, 0, 4, 4);
    div4("d0_5",   4'd0,  4'd5,  0,  0, 0, 4, 4);
    div4("d15_15", 4'd15, 4'd15, 1,  0, 0, 4, 4);
    div4("d9_0",   4'd9,  4'd0,  15, 9, 1, DBZ_LAT, DBZ_BUSY);

    // reset in the middle of 11/2
    @(negedge clk);
    start4 = 1'b1; dvd4 = 4'd11; dvs4 = 4'd2;
    @(negedge clk);
    start4 = 1'b0;
    check("mid_busy_before_rst", {31'b0, busy4}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",  {31'b0, busy4}, 0);
    check("mrst_ready", {31'b0, ready4}, 0);
    check("mrst_q",     {28'b0, q4}, 0);
    check("mrst_r",     {28'b0, r4}, 0);
    check("mrst_dbz",   {31'b0, dbz4}, 0);
    repeat (3) @(negedge clk);
    check("mrst_stays_idle", {31'b0, busy4 | ready4}, 0);
    div4("d11_2", 4'd11, 4'd2, 5, 1, 0, 4, 4);

    // start during busy is ignored; old results held after accept
    @(negedge clk);
    start4 = 1'b1; dvd4 = 4'd13; dvs4 = 4'd4;
    @(negedge clk);
    start4 = 1'b0;
    check("ign_ready_drop", {31'b0, ready4}, 0);
    check("ign_busy",       {31'b0, busy4}, 1);
    check("ign_q_held",     {28'b0, q4}, 5);
    check("ign_r_held",     {28'b0, r4}, 1);
    @(negedge clk);
    start4 = 1'b1; dvd4 = 4'd6; dvs4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    lat = 2;
    while (!ready4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", lat, 4);
    check("ign_q",   {28'b0, q4}, 3);
    check("ign_r",   {28'b0, r4}, 1);
    repeat (2) @(negedge clk);
    check("ign_no_restart_busy",  {31'b0, busy4}, 0);
    check("ign_no_restart_ready", {31'b0, ready4}, 1);

    // N=8 start held high: back-to-back divisions
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd255; dvs8 = 8'd16;
    @(negedge clk);
    lat = 0;
    while (!ready8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("held1_lat", lat, 8);
    check("held1_q", {24'b0, q8}, 15);
    check("held1_r", {24'b0, r8}, 15);
    dvd8 = 8'd200; dvs8 = 8'd7;
    @(negedge clk);
    check("held_ready_1cyc", {31'b0, ready8}, 0);
    check("held2_busy",      {31'b0, busy8}, 1);
    lat = 0;
    while (!ready8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    check("held2_lat", lat, 8);
    check("held2_q",   {24'b0, q8}, 28);
    check("held2_r",   {24'b0, r8}, 4);
    check("held2_dbz", {31'b0, dbz8}, 0);

    // random N=8 vectors, nonzero divisors
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      exp_q.push_back({8'(a / b), 8'(a % b)});
      run8(8'(a), 8'(b), lat);
      e = exp_q.pop_front();
      check("rnd_q",   {24'b0, q8}, {24'b0, e[15:8]});
      check("rnd_r",   {24'b0, r8}, {24'b0, e[7:0]});
      check("rnd_inv", 32'(q8) * 32'(b) + 32'(r8), a);
      check("rnd_rlt", {31'b0, (32'(r8) < b)}, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Iterative restoring divider: unsigned N-bit dividend by N-bit divisor, producing quotient and remainder one bit per clock. It is the inverse datapath of the team's shift-and-add multiplier and uses the same start/ready handshake, so both units can share one arithmetic controller. The divider runs in N cycles. Divide-by-zero is flagged rather than trapped.

## Interface
- N, default 4, operand width in bits (N ≥ 2).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only while busy=0.
- busy  output  1  high while a division is in progress.
- ready  output  1  result valid; stays high until the next accepted start or reset.
- dividend  input  N  unsigned dividend, captured on the accepting edge.
- divisor  input  N  unsigned divisor, captured on the accepting edge.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  last completed division had divisor=0; valid while ready=1.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1. A log2(N)+1-bit counter counts iterations 0..N-1.
- Accept:
  - start=1 in IDLE → capture dividend into the shift register and divisor into a holding register.
  - Clear the N+1-bit partial remainder R and the counter.
  - Set ready=0 and busy=1, and go to RUN.
  - Record the divisor==0 status internally.
- RUN iteration, one per cycle:
  - R ← {R[N-1:0], dividend_sreg MSB}. Shift dividend_sreg left.
  - If R ≥ {0,divisor}, then R ← R − divisor and the shifted-in quotient bit is 1. Otherwise R is kept and the bit is 0.
  - Quotient bits collect MSB-first, in the register freed by the dividend shift.
- Completion: on the edge that performs iteration N-1:
  - Load quotient, remainder=R[N-1:0] and div_by_zero.
  - Set ready=1 and busy=0, and return to IDLE.
- quotient, remainder and div_by_zero hold their last completed values until the next completion. Accepting a new start does not clear them; only ready drops.
- start while busy=1 is ignored; no queuing.
- start held high continuously: a new division is accepted on the first edge where busy=0. The prior result is visible (ready=1) for one cycle.
- Divisor 0, normal path: the algorithm naturally yields quotient = all ones (2^N−1) and remainder = dividend, with div_by_zero=1.
- Arithmetic: all unsigned. The compare/subtract uses N+1 bits, so there is no overflow. The invariant dividend = quotient·divisor + remainder holds for every divisor ≠ 0, with remainder < divisor.

## Timing
- Reset values: busy=0, ready=0, quotient=0, remainder=0, div_by_zero=0; state IDLE.
- rst=1 on any edge, including mid-RUN, aborts the operation and forces the reset values on that edge. rst has priority over start.
- Latency: start accepted at edge E0 → ready=1 and results valid after edge E0+N. busy is high from E0 through E0+N−1.
- Throughput: one division every N+1 cycles with start held high. ready and busy are never both 1.

## Configuration
- DIVIDER_DBZ_SHORTCUT_EN
  - Defined: accepting a start with divisor=0 skips RUN. The same edge E0 loads quotient=2^N−1, remainder=dividend and div_by_zero=1, sets ready=1, and busy stays 0. Latency is 1 edge.
  - Undefined: divisor=0 takes the full N-cycle path with the identical result values.
  - Nonzero divisors are unaffected in both cases.

## Test plan
- N=4, 13÷4: start at E0 → after E0+4, ready=1, quotient=3, remainder=1, div_by_zero=0; busy high for exactly 4 cycles.
- N=4 boundary operands: 15÷1 → q=15, r=0; 7÷9 → q=0, r=7; 0÷5 → q=0, r=0; 15÷15 → q=1, r=0.
- N=4, 9÷0:
  - Without the macro: q=15, r=9, div_by_zero=1 after 4 cycles.
  - With DIVIDER_DBZ_SHORTCUT_EN: the same values after 1 edge, busy never high.
- Start 13÷4, then pulse start with 6÷3 at E0+2 → the second request is ignored; the result after E0+4 is q=3, r=1.
- Start 11÷2, assert rst at E0+2 → all outputs 0 after that edge. A new 11÷2 start then completes normally: q=5, r=1.
- N=8, start held high with 255÷16 then 200÷7 → q=15, r=15 (ready high 1 cycle), then q=28, r=4. Randomized check of q·d+r=dividend over 1000 vectors.
